// File: rtl/fsm_step_driver.sv
// Initiator for the four-state stepping FSM: issues one-hot step requests phase by
// phase, checks the returned one-hot status, and counts full laps to completion.
module fsm_step_driver #(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned LAPS_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LAPS_W-1:0] laps,
  output logic [3:0]        step_req,
  input  logic [3:0]        state_status,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [LAPS_W-1:0] lap_count
);

  localparam int unsigned CNT_W     = 8;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;
  localparam logic [1:0] ERR_NOINIT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         ph;
  logic [CNT_W-1:0]   wait_cnt;
  logic [LAPS_W-1:0]  laps_q;

  logic [1:0]         ph_next;
  logic [3:0]         exp_status;
  logic [3:0]         cur_status;
  logic [LAPS_W-1:0]  lap_next;

  function automatic logic [3:0] onehot(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

  assign ph_next    = ph + 2'd1;
  assign exp_status = onehot(ph_next);
  assign cur_status = onehot(ph);
  assign lap_next   = lap_count + LAPS_W'(1);

  // step_req is loaded on entry to ISSUE so it is high exactly during the ISSUE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ph        <= 2'd0;
      wait_cnt  <= '0;
      laps_q    <= '0;
      step_req  <= 4'b0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= 2'd0;
      lap_count <= '0;
    end else begin
      step_req <= 4'b0000;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (state_status == 4'b0001) begin
              error     <= 1'b0;
              err_code  <= 2'd0;
              lap_count <= '0;
              laps_q    <= laps;
              ph        <= 2'd0;
              if (laps == '0) begin
                done <= 1'b1;
              end else begin
                state    <= ISSUE;
                busy     <= 1'b1;
                step_req <= 4'b0001;
              end
            end else begin
              error    <= 1'b1;
              err_code <= ERR_NOINIT;
            end
          end
        end

        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          if (state_status == exp_status) begin
            ph <= ph_next;
            if (ph_next == 2'd0 && lap_next == laps_q) begin
              lap_count <= lap_next;
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              if (ph_next == 2'd0) lap_count <= lap_next;
              state    <= ISSUE;
              step_req <= exp_status;
            end
          end else if (state_status == cur_status) begin
            // FSM status still shows the old phase; it lags by design
            if (wait_cnt == WAIT_LAST) begin
              state    <= IDLE;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end else begin
            state    <= IDLE;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= ERR_ILLEGAL;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_step_driver.sv
// Bench for fsm_step_driver: a behavioural stepping FSM with fault hooks, run traces
// logged per cycle and compared against hand-derived cycle expectations.
module tb_fsm_step_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] laps;
  logic [3:0] step_req;
  logic [3:0] state_status;
  logic       busy, done, error;
  logic [1:0] err_code;
  logic [7:0] lap_count;

  // FSM model controls
  logic       m_rst;
  logic       ign2;
  logic       force_en;
  logic [1:0] m_state;
  logic [3:0] m_status;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] log_step [0:63];
  logic       log_busy [0:63];
  logic       log_done [0:63];
  logic       log_err  [0:63];
  logic [1:0] log_code [0:63];
  logic [7:0] log_lc   [0:63];

  typedef struct {
    int         cyc;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] code;
    logic [7:0] lc;
  } vec_t;

  fsm_step_driver #(.TIMEOUT(8), .LAPS_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .laps(laps),
    .step_req(step_req), .state_status(state_status),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .lap_count(lap_count)
  );

  always #5 clk = ~clk;

  // Stepping FSM: state advances on any step request, status is a registered copy of state
  always @(posedge clk) begin
    if (m_rst) begin
      m_state  <= 2'd0;
      m_status <= 4'b0001;
    end else begin
      if (step_req != 4'b0000 && !(ign2 && step_req == 4'b0100))
        m_state <= m_state + 2'd1;
      m_status <= 4'b0001 << m_state;
    end
  end

  assign state_status = force_en ? 4'b0110 : m_status;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start in cycle 0, then log outputs for cycles 1..ncyc while applying per-cycle hooks
  task automatic run(input logic [7:0] l, input int ncyc, input int fc,
                     input int s1, input int s2, input int rc);
    start = 1'b1;
    laps  = l;
    for (int n = 1; n <= ncyc; n++) begin
      tick();
      log_step[n] = step_req;
      log_busy[n] = busy;
      log_done[n] = done;
      log_err[n]  = error;
      log_code[n] = err_code;
      log_lc[n]   = lap_count;
      start    = (n == s1) || (n == s2);
      force_en = (n == fc);
      reset    = (n == rc);
      m_rst    = (n == rc);
    end
    start = 1'b0; force_en = 1'b0; reset = 1'b0; m_rst = 1'b0;
  endtask

  task automatic model_reset();
    m_rst = 1'b1; tick();
    m_rst = 1'b0; tick();
  endtask

  initial begin
    vec_t v [10];
    int   nz;
    logic [3:0] exp_step;

    v[0] = '{1,  1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    v[1] = '{2,  1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    v[2] = '{12, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    v[3] = '{13, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};
    v[4] = '{16, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};
    v[5] = '{24, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};
    v[6] = '{25, 1'b0, 1'b1, 1'b0, 2'd0, 8'd2};
    v[7] = '{26, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2};
    v[8] = '{11, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    v[9] = '{23, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};

    reset = 1'b1; m_rst = 1'b1; start = 1'b0; laps = 8'd0;
    ign2 = 1'b0; force_en = 1'b0;
    tick(); tick();
    reset = 1'b0; m_rst = 1'b0;
    tick();
    chk("reset step_req", int'(step_req), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset error", int'(error), 0);
    chk("reset err_code", int'(err_code), 0);
    chk("reset lap_count", int'(lap_count), 0);

    // Two laps with an ideal FSM
    run(8'd2, 26, -1, -1, -1, -1);
    nz = 0;
    for (int n = 1; n <= 26; n++) begin
      exp_step = ((n - 1) % 3 == 0 && n <= 22) ? (4'b0001 << (((n - 1) / 3) % 4)) : 4'b0000;
      if (log_step[n] != 4'b0000) nz++;
      if (exp_step != 4'b0000 || n == 2 || n == 12 || n == 25)
        chk($sformatf("laps2 step_req@%0d", n), int'(log_step[n]), int'(exp_step));
    end
    chk("laps2 step pulse count", nz, 8);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("laps2 busy@%0d", v[i].cyc), int'(log_busy[v[i].cyc]), int'(v[i].busy));
      chk($sformatf("laps2 done@%0d", v[i].cyc), int'(log_done[v[i].cyc]), int'(v[i].done));
      chk($sformatf("laps2 error@%0d", v[i].cyc), int'(log_err[v[i].cyc]), int'(v[i].err));
      chk($sformatf("laps2 err_code@%0d", v[i].cyc), int'(log_code[v[i].cyc]), int'(v[i].code));
      chk($sformatf("laps2 lap_count@%0d", v[i].cyc), int'(log_lc[v[i].cyc]), int'(v[i].lc));
    end

    // Zero laps: immediate done, never busy
    tick();
    run(8'd0, 4, -1, -1, -1, -1);
    chk("laps0 done@1", int'(log_done[1]), 1);
    chk("laps0 done@2", int'(log_done[2]), 0);
    for (int n = 1; n <= 4; n++) begin
      chk($sformatf("laps0 busy@%0d", n), int'(log_busy[n]), 0);
      chk($sformatf("laps0 step_req@%0d", n), int'(log_step[n]), 0);
    end
    chk("laps0 lap_count", int'(log_lc[2]), 0);

    // FSM ignores the third step: timeout
    tick();
    ign2 = 1'b1;
    run(8'd1, 20, -1, -1, -1, -1);
    chk("timeout step_req@7", int'(log_step[7]), 4);
    chk("timeout error@15", int'(log_err[15]), 0);
    chk("timeout busy@15", int'(log_busy[15]), 1);
    chk("timeout error@16", int'(log_err[16]), 1);
    chk("timeout err_code@16", int'(log_code[16]), 1);
    chk("timeout busy@16", int'(log_busy[16]), 0);
    chk("timeout lap_count@16", int'(log_lc[16]), 0);
    chk("timeout done@16", int'(log_done[16]), 0);
    for (int n = 8; n <= 20; n++)
      chk($sformatf("timeout no step@%0d", n), int'(log_step[n]), 0);
    chk("timeout sticky@20", int'(log_err[20]), 1);

    // FSM left at phase 2: start must be refused with code 3
    tick();
    run(8'd1, 4, -1, -1, -1, -1);
    chk("noinit error@1", int'(log_err[1]), 1);
    chk("noinit err_code@1", int'(log_code[1]), 3);
    for (int n = 1; n <= 4; n++) begin
      chk($sformatf("noinit step_req@%0d", n), int'(log_step[n]), 0);
      chk($sformatf("noinit busy@%0d", n), int'(log_busy[n]), 0);
    end
    ign2 = 1'b0;
    model_reset();

    // Multi-hot status forced in cycle 5
    run(8'd1, 15, 5, -1, -1, -1);
    chk("illegal error@1", int'(log_err[1]), 0);
    chk("illegal step_req@4", int'(log_step[4]), 2);
    chk("illegal error@5", int'(log_err[5]), 0);
    chk("illegal error@6", int'(log_err[6]), 1);
    chk("illegal err_code@6", int'(log_code[6]), 2);
    chk("illegal busy@6", int'(log_busy[6]), 0);
    for (int n = 5; n <= 15; n++)
      chk($sformatf("illegal no step@%0d", n), int'(log_step[n]), 0);
    model_reset();

    // Recovery run with stray starts in cycles 5 and 8
    run(8'd1, 14, -1, 5, 8, -1);
    chk("recover error@1", int'(log_err[1]), 0);
    chk("recover err_code@1", int'(log_code[1]), 0);
    chk("recover step_req@7", int'(log_step[7]), 4);
    chk("recover step_req@10", int'(log_step[10]), 8);
    chk("recover done@12", int'(log_done[12]), 0);
    chk("recover done@13", int'(log_done[13]), 1);
    chk("recover busy@13", int'(log_busy[13]), 0);
    chk("recover lap_count@13", int'(log_lc[13]), 1);
    chk("recover step_req@13", int'(log_step[13]), 0);
    chk("recover done@14", int'(log_done[14]), 0);

    // Reset in cycle 8 of a three-lap run
    tick();
    run(8'd3, 12, -1, -1, -1, 8);
    chk("rst busy@8", int'(log_busy[8]), 1);
    chk("rst busy@9", int'(log_busy[9]), 0);
    chk("rst step_req@9", int'(log_step[9]), 0);
    chk("rst done@9", int'(log_done[9]), 0);
    chk("rst error@9", int'(log_err[9]), 0);
    chk("rst err_code@9", int'(log_code[9]), 0);
    chk("rst lap_count@9", int'(log_lc[9]), 0);
    chk("rst step_req@10", int'(log_step[10]), 0);

    run(8'd3, 40, -1, -1, -1, -1);
    chk("laps3 lap_count@25", int'(log_lc[25]), 2);
    chk("laps3 busy@36", int'(log_busy[36]), 1);
    chk("laps3 done@36", int'(log_done[36]), 0);
    chk("laps3 done@37", int'(log_done[37]), 1);
    chk("laps3 busy@37", int'(log_busy[37]), 0);
    chk("laps3 lap_count@37", int'(log_lc[37]), 3);
    chk("laps3 error@37", int'(log_err[37]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_step_driver.md
# fsm_step_driver

Initiator-side companion to the four-state stepping FSM (INIT -> ONE -> TWO -> THREE -> INIT). It drives the FSM's 4-bit step-request inputs one phase at a time and checks the FSM's registered one-hot status outputs for each transition. It runs a requested number of full laps and reports completion, or reports a timeout or protocol error. It sits beside the FSM in the control fabric and is the only agent driving its inputs.

## Interface
- TIMEOUT, 8: number of WAIT cycles allowed for the expected status before a timeout error; legal range 2..255.
- LAPS_W, 8: width of `laps` and `lap_count`.

- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- start  input  1  one-cycle run request; sampled only in IDLE
- laps  input  LAPS_W  number of full laps to run; sampled with `start`
- step_req  output  4  registered; to FSM step inputs; at most one bit high, for one cycle per step
- state_status  input  4  from FSM registered one-hot status
- busy  output  1  registered; high from the cycle after `start` is accepted until the run ends
- done  output  1  registered; one-cycle pulse on successful completion
- error  output  1  registered; sticky until the next accepted `start` or `reset`
- err_code  output  2  registered; 0 none, 1 timeout, 2 illegal status, 3 not at INIT on start
- lap_count  output  LAPS_W  registered; laps completed in the current or last run

## Operation
- States: IDLE, ISSUE, WAIT.
  - A phase register `ph` (0..3) tracks the expected FSM state.
  - A wait counter and a lap counter are also kept.
- IDLE:
  - On `start` with `state_status` == 4'b0001: clear `error`, `err_code` and `lap_count`, latch `laps`, set `ph`=0.
    - If `laps` == 0: pulse `done` next cycle and stay in IDLE; `busy` stays low.
    - Otherwise go to ISSUE.
  - On `start` with any other status: next cycle `error`=1, `err_code`=3; no `step_req`; stay in IDLE.
- ISSUE (one cycle):
  - `step_req` = one-hot(`ph`) during this cycle.
  - Clear the wait counter and go to WAIT.
- WAIT:
  - Expected status is one-hot((`ph`+1) mod 4).
  - Status equal to the expected value: `ph` <= `ph`+1 mod 4.
    - If the new `ph` is 0, increment `lap_count`. If `lap_count` then equals `laps`, go to IDLE, drop `busy` and pulse `done`; otherwise go to ISSUE.
    - If the new `ph` is not 0, go to ISSUE.
  - Status equal to one-hot(`ph`): the FSM has not yet updated; increment the wait counter.
    - When the counter reaches TIMEOUT, go to IDLE with `error`=1, `err_code`=1.
  - Any other status (zero, multi-hot, or the wrong phase): go to IDLE with `error`=1, `err_code`=2.
- On any error:
  - `busy` drops in the same cycle `error` rises.
  - `step_req` = 0.
  - `lap_count` holds the number of laps completed.
- `start` outside IDLE is ignored.
- `reset` in any state forces IDLE on the next edge and clears all registers. A step in flight is abandoned.

## Timing
- Reset values: `step_req`=0, `busy`=0, `done`=0, `error`=0, `err_code`=0, `lap_count`=0.
- The FSM status lags its state by one cycle. `step_req` high in cycle c gives the new one-hot status in cycle c+2.
- Cycle numbering below takes `start` high in cycle 0, with an ideal FSM:
  - `busy`=1 from cycle 1.
  - Step k request in cycle 1+3k: 4'b0001 @1, 4'b0010 @4, 4'b0100 @7, 4'b1000 @10.
  - Status returns to 4'b0001 in cycle 12.
  - One lap = 12 cycles; lap n ends with status 4'b0001 in cycle 12n.
  - For `laps`=N: `done`=1 and `busy`=0 in cycle 12N+1.
- Timeout with the request in cycle c and no status change: `error` rises in cycle c+1+TIMEOUT.
- Illegal status seen in cycle t: `error` rises in cycle t+1.
- `lap_count` updates in the cycle after the lap-closing status is seen.

## Test plan
- Reset, then `start` with `laps`=2 and the FSM attached -> step_req pulses 4'b0001, 4'b0010, 4'b0100, 4'b1000 at cycles 1, 4, 7, 10, 13, 16, 19, 22; `done` high at cycle 25; `lap_count`=2; `error`=0.
- `start` with `laps`=0 -> `done` high at cycle 1; `busy` never high; `step_req` stays 0.
- Model the FSM ignoring step 2 (status stuck at 4'b0100), TIMEOUT=8 -> step_req 4'b0100 at cycle 7; `error`=1, `err_code`=1 at cycle 16; `busy`=0; `lap_count`=0.
- Force status 4'b0110 at cycle 5 of a run -> `error`=1, `err_code`=2 at cycle 6; no further `step_req`. A following `start` with status 4'b0001 clears the error and the run completes normally.
- `start` while status is 4'b0100 -> `error`=1, `err_code`=3 at cycle 1; `step_req` stays 0. `start` pulses at cycles 5 and 8 during a normal run -> ignored.
- Assert `reset` in cycle 8 of a `laps`=3 run -> all outputs 0 from cycle 9. A new `start` after the FSM status returns to 4'b0001 completes 3 laps.
